// File: rtl/cm0_dap_jt_cdc_req_sync.sv
// cm0_dap_jt_cdc_req_sync: destination-side receiver of a 4-phase req/ack crossing.
// Synchronises the masked request, captures quasi-static data and offers it via valid/ready.
module cm0_dap_jt_cdc_req_sync #(
    parameter int PRESENT     = 1,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reqin,
    input  logic [DW-1:0] datain,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] dataout,
    output logic          ackout,
    output logic          abort
);

    generate
        if (PRESENT == 0) begin : gAbsent
            logic unusedInputs;
            assign unusedInputs = ^{clk, reset, reqin, datain, ready};
            assign valid   = 1'b0;
            assign dataout = '0;
            assign ackout  = 1'b0;
            assign abort   = 1'b0;
        end else begin : gPresent
            typedef enum logic [1:0] {
                IDLE = 2'd0,
                PEND = 2'd1,
                ACK  = 2'd2
            } state_t;

            logic [SYNC_STAGES-1:0] syncReg;
            logic                   reqSync;
            state_t                 state, stateNext;
            logic                   validReg, validNext;
            logic                   ackReg, ackNext;
            logic                   abortReg, abortNext;
            logic [DW-1:0]          dataReg, dataNext;

            // Bare flop chain: reqin lands directly in stage 1 with no logic in front of it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    syncReg <= '0;
                end else begin
                    syncReg <= {syncReg[SYNC_STAGES-2:0], reqin};
                end
            end

            assign reqSync = syncReg[SYNC_STAGES-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state    <= IDLE;
                    validReg <= 1'b0;
                    ackReg   <= 1'b0;
                    abortReg <= 1'b0;
                    dataReg  <= '0;
                end else begin
                    state    <= stateNext;
                    validReg <= validNext;
                    ackReg   <= ackNext;
                    abortReg <= abortNext;
                    dataReg  <= dataNext;
                end
            end

            // Acceptance wins over withdrawal when both are seen in the same PEND cycle.
            always_comb begin
                stateNext = state;
                validNext = validReg;
                ackNext   = ackReg;
                abortNext = 1'b0;
                dataNext  = dataReg;
                case (state)
                    IDLE: begin
                        if (reqSync) begin
                            dataNext  = datain;
                            validNext = 1'b1;
                            stateNext = PEND;
                        end
                    end
                    PEND: begin
                        if (ready) begin
                            validNext = 1'b0;
                            ackNext   = 1'b1;
                            stateNext = ACK;
                        end else if (!reqSync) begin
                            validNext = 1'b0;
                            abortNext = 1'b1;
                            stateNext = IDLE;
                        end
                    end
                    ACK: begin
                        if (!reqSync) begin
                            ackNext   = 1'b0;
                            stateNext = IDLE;
                        end
                    end
                    default: begin
                        validNext = 1'b0;
                        ackNext   = 1'b0;
                        stateNext = IDLE;
                    end
                endcase
            end

            assign valid   = validReg;
            assign dataout = dataReg;
            assign ackout  = ackReg;
            assign abort   = abortReg;
        end
    endgenerate

endmodule

// File: tb/tb_cm0_dap_jt_cdc_req_sync.sv
// tb_cm0_dap_jt_cdc_req_sync: vector table, corner sequences and randomized transfers
// scored against a transaction-level model; also exercises PRESENT=0 and SYNC_STAGES=4 builds.
module tb_cm0_dap_jt_cdc_req_sync;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqin;
    logic [DW-1:0] datain;
    logic          ready;
    logic          valid, ackout, abort;
    logic [DW-1:0] dataout;

    logic          validNp, ackoutNp, abortNp;
    logic [DW-1:0] dataoutNp;

    logic          req4, ready4;
    logic [DW-1:0] data4;
    logic          valid4, ackout4, abort4;
    logic [DW-1:0] dataout4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          rdy;
        logic          expValid;
        logic          expAck;
        logic          expAbort;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] expWords[$];
    logic [DW-1:0] recvWords[$];
    int            expAborts;
    int            abortSeen;

    cm0_dap_jt_cdc_req_sync #(.PRESENT(1), .DW(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .reqin(reqin), .datain(datain), .ready(ready),
        .valid(valid), .dataout(dataout), .ackout(ackout), .abort(abort)
    );

    cm0_dap_jt_cdc_req_sync #(.PRESENT(0), .DW(DW), .SYNC_STAGES(2)) dutNp (
        .clk(clk), .reset(reset), .reqin(reqin), .datain(datain), .ready(ready),
        .valid(validNp), .dataout(dataoutNp), .ackout(ackoutNp), .abort(abortNp)
    );

    cm0_dap_jt_cdc_req_sync #(.PRESENT(1), .DW(DW), .SYNC_STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .reqin(req4), .datain(data4), .ready(ready4),
        .valid(valid4), .dataout(dataout4), .ackout(ackout4), .abort(abort4)
    );

    always #5 clk = ~clk;

    // Consumer-side monitor: records every word handed over and every abort pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) recvWords.push_back(dataout);
            if (abort) abortSeen++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        checkOutput("absent_outputs_zero", {validNp, ackoutNp, abortNp, dataoutNp}, 64'd0);
    endtask

    task automatic checkMain(input string name, input logic v, input logic a, input logic ab,
                             input logic [DW-1:0] d);
        checkOutput(name, {valid, ackout, abort, dataout}, {v, a, ab, d});
    endtask

    task automatic addVec(input logic r, input logic [DW-1:0] d, input logic rd,
                          input logic ev, input logic ea, input logic eab, input logic [DW-1:0] ed);
        vec_t v;
        v.req = r; v.data = d; v.rdy = rd;
        v.expValid = ev; v.expAck = ea; v.expAbort = eab; v.expData = ed;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        reqin  = v.req;
        datain = v.data;
        ready  = v.rdy;
        stepCycle();
        checkMain($sformatf("vec%0d", idx), v.expValid, v.expAck, v.expAbort, v.expData);
    endtask

    task automatic runTransfer(input logic [DW-1:0] d, input bit doAccept, input int hold,
                               input int linger);
        reqin  = 1'b1;
        datain = d;
        for (int e = 1; e <= 3; e++) begin
            ready = 1'($urandom_range(0, 1));
            stepCycle();
            if (e < 3) checkOutput("rand_latency_low", valid, 1'b0);
            else checkOutput("rand_capture", {valid, dataout}, {1'b1, d});
        end
        ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            stepCycle();
            checkOutput("rand_hold", {valid, ackout, dataout}, {2'b10, d});
        end
        if (doAccept) begin
            ready = 1'b1;
            stepCycle();
            checkOutput("rand_accept", {valid, ackout, abort}, 3'b010);
            expWords.push_back(d);
            for (int i = 0; i < linger; i++) begin
                ready = 1'($urandom_range(0, 1));
                stepCycle();
                checkOutput("rand_ack_hold", {valid, ackout}, 2'b01);
            end
            reqin = 1'b0;
            for (int e = 1; e <= 3; e++) begin
                ready = 1'($urandom_range(0, 1));
                stepCycle();
                checkOutput("rand_ack_release", ackout, (e < 3) ? 1'b1 : 1'b0);
            end
            ready = 1'b0;
        end else begin
            reqin = 1'b0;
            for (int e = 1; e <= 4; e++) begin
                stepCycle();
                checkMain("rand_abort", (e < 3), 1'b0, (e == 3), d);
            end
            expAborts++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        reqin  = 1'b1;
        datain = 32'h1111_2222;
        ready  = 1'b0;
        req4   = 1'b0;
        data4  = '0;
        ready4 = 1'b0;

        // Reset held with the request already high.
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkMain("reset_hold", 1'b0, 1'b0, 1'b0, '0);
        end
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            stepCycle();
            if (e < 3) checkMain("post_reset_wait", 1'b0, 1'b0, 1'b0, '0);
            else checkMain("post_reset_capture", 1'b1, 1'b0, 1'b0, 32'h1111_2222);
        end
        #3 reset = 1'b1;
        #1 checkMain("async_reset_drop", 1'b0, 1'b0, 1'b0, '0);
        reqin = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkMain("idle_after_reset", 1'b0, 1'b0, 1'b0, '0);
        end

        // Basic transfer, back-to-back, abort, ready coincident with withdrawal.
        addVec(1, 32'hA5A5_0001, 1, 0, 0, 0, 32'h0);
        addVec(1, 32'hA5A5_0001, 1, 0, 0, 0, 32'h0);
        addVec(1, 32'hA5A5_0001, 0, 1, 0, 0, 32'hA5A5_0001);
        addVec(1, 32'hA5A5_0001, 0, 1, 0, 0, 32'hA5A5_0001);
        addVec(1, 32'hA5A5_0001, 1, 0, 1, 0, 32'hA5A5_0001);
        addVec(0, 32'hA5A5_0001, 0, 0, 1, 0, 32'hA5A5_0001);
        addVec(0, 32'hA5A5_0001, 0, 0, 1, 0, 32'hA5A5_0001);
        addVec(0, 32'hA5A5_0001, 0, 0, 0, 0, 32'hA5A5_0001);
        addVec(1, 32'h0000_0002, 0, 0, 0, 0, 32'hA5A5_0001);
        addVec(1, 32'h0000_0002, 0, 0, 0, 0, 32'hA5A5_0001);
        addVec(1, 32'h0000_0002, 0, 1, 0, 0, 32'h0000_0002);
        addVec(1, 32'h0000_0002, 1, 0, 1, 0, 32'h0000_0002);
        addVec(0, 32'h0000_0002, 0, 0, 1, 0, 32'h0000_0002);
        addVec(0, 32'h0000_0002, 0, 0, 1, 0, 32'h0000_0002);
        addVec(0, 32'h0000_0002, 0, 0, 0, 0, 32'h0000_0002);
        addVec(1, 32'h0BAD_0003, 0, 0, 0, 0, 32'h0000_0002);
        addVec(1, 32'h0BAD_0003, 0, 0, 0, 0, 32'h0000_0002);
        addVec(1, 32'h0BAD_0003, 0, 1, 0, 0, 32'h0BAD_0003);
        addVec(0, 32'h0BAD_0003, 0, 1, 0, 0, 32'h0BAD_0003);
        addVec(0, 32'h0BAD_0003, 0, 1, 0, 0, 32'h0BAD_0003);
        addVec(0, 32'h0BAD_0003, 0, 0, 0, 1, 32'h0BAD_0003);
        addVec(0, 32'h0BAD_0003, 0, 0, 0, 0, 32'h0BAD_0003);
        addVec(1, 32'h0000_0004, 0, 0, 0, 0, 32'h0BAD_0003);
        addVec(1, 32'h0000_0004, 0, 0, 0, 0, 32'h0BAD_0003);
        addVec(1, 32'h0000_0004, 0, 1, 0, 0, 32'h0000_0004);
        addVec(0, 32'h0000_0004, 0, 1, 0, 0, 32'h0000_0004);
        addVec(0, 32'h0000_0004, 0, 1, 0, 0, 32'h0000_0004);
        addVec(0, 32'h0000_0004, 1, 0, 1, 0, 32'h0000_0004);
        addVec(0, 32'h0000_0004, 0, 0, 0, 0, 32'h0000_0004);
        addVec(0, 32'h0000_0004, 1, 0, 0, 0, 32'h0000_0004);
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        ready = 1'b0;

        // Randomized transfers scored by word order and abort count.
        recvWords.delete();
        expWords.delete();
        expAborts = 0;
        abortSeen = 0;
        for (int t = 0; t < 100; t++) begin
            runTransfer($urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                        $urandom_range(0, 2));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                datain = $urandom;
                ready  = 1'($urandom_range(0, 1));
                stepCycle();
            end
            ready = 1'b0;
        end
        stepCycle();
        checkOutput("score_word_count", recvWords.size(), expWords.size());
        checkOutput("score_abort_count", abortSeen, expAborts);
        for (int i = 0; i < expWords.size() && i < recvWords.size(); i++)
            checkOutput($sformatf("score_word%0d", i), recvWords[i], expWords[i]);

        // Four-stage synchroniser build: capture and release both take five edges.
        req4  = 1'b1;
        data4 = 32'h0000_0055;
        for (int e = 1; e <= 5; e++) begin
            stepCycle();
            if (e < 5) checkOutput("sync4_latency_low", valid4, 1'b0);
            else checkOutput("sync4_capture", {valid4, dataout4}, {1'b1, 32'h0000_0055});
        end
        ready4 = 1'b1;
        stepCycle();
        checkOutput("sync4_accept", {valid4, ackout4, abort4}, 3'b010);
        ready4 = 1'b0;
        req4   = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            stepCycle();
            checkOutput("sync4_ack_release", ackout4, (e < 5) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cm0_dap_jt_cdc_req_sync.md
Name: cm0_dap_jt_cdc_req_sync

Overview:
Destination-side receiver for a 4-phase req/ack clock-domain crossing in the DAP JTAG path. It consumes the glitch-free masked request produced by the upstream CDC AND-mask stage, and samples an accompanying quasi-static data bus. It synchronises the request, captures the data and presents it locally with a VALID/READY handshake. It returns a registered ACKOUT to the source domain and cancels cleanly when the request is withdrawn (masked) before acceptance.

Parameters:
PRESENT, 1, 0 removes the block: all outputs tied 0, no flops inferred.
DW, 32, width of DATAIN/DATAOUT (1..64).
SYNC_STAGES, 2, request synchroniser depth (2..4).

Ports:
CLK  input  1  destination-domain clock.
RESET  input  1  asynchronous, active-high reset.
REQIN  input  1  asynchronous request from the upstream mask; glitch-free, 4-phase.
DATAIN  input  DW  asynchronous data; stable while REQIN high.
READY  input  1  local consumer accepts DATAOUT.
VALID  output  1  DATAOUT holds a captured, unaccepted word.
DATAOUT  output  DW  captured data.
ACKOUT  output  1  registered acknowledge to the source domain.
ABORT  output  1  one-cycle pulse: request withdrawn before acceptance.

Behaviour:
- Reset (async assert, sync release): sync chain=0, state=IDLE, VALID=0, ACKOUT=0, ABORT=0, DATAOUT=0.
- Synchroniser: SYNC_STAGES flops on REQIN; req_s = last stage. No logic on REQIN before stage 1. DATAIN is never synchronised, only sampled when req_s=1.
- Sync latency: REQIN high before edge 1 -> req_s high after edge SYNC_STAGES.
- FSM states: IDLE, PEND, ACK. All outputs registered.
- IDLE, req_s=1 -> DATAOUT<=DATAIN, VALID<=1, go PEND. VALID rises after edge SYNC_STAGES+1.
- PEND, READY=1 -> VALID<=0, ACKOUT<=1, go ACK. Evaluated before the abort check.
- PEND, READY=0 and req_s=0 -> VALID<=0, ABORT<=1 for one cycle, go IDLE. ACKOUT never asserted.
- PEND, otherwise: hold. VALID and DATAOUT stay stable.
- ACK, req_s=0 -> ACKOUT<=0, go IDLE. Otherwise hold ACKOUT=1.
- IDLE after ACK: a new req_s=1 is accepted on the next edge, with no dead cycle beyond synchroniser latency.
- READY is ignored while VALID=0.
- READY and req_s falling in the same PEND cycle: the transfer completes (ACKOUT=1). ACK then sees req_s=0 and drops ACKOUT after one cycle.
- DATAOUT changes only on capture. It holds the last word after accept, abort and return to IDLE.
- ABORT is high for exactly one cycle and is never coincident with VALID rising.
- Reset mid-transfer: VALID/ACKOUT drop asynchronously. The source sees ACKOUT low and must re-handshake.
- PRESENT=0: VALID=ACKOUT=ABORT=0, DATAOUT=0, inputs unused.

Test Plan:
1. Reset with REQIN=1 held -> all outputs 0 during reset. After release, VALID rises at edge SYNC_STAGES+1 (3 cycles for default) with DATAOUT=DATAIN.
2. Basic transfer, DW=32, SYNC_STAGES=2: DATAIN=0xA5A5_0001, REQIN rises. VALID=1 with DATAOUT=0xA5A5_0001. READY=1 for one cycle -> VALID=0, ACKOUT=1 next edge. REQIN drops -> ACKOUT=0 three edges later.
3. Back-to-back: second REQIN rise with DATAIN=0x0000_0002, one cycle after ACKOUT falls -> VALID rises SYNC_STAGES+1 edges later with DATAOUT=0x2. No lost or duplicated words over 100 random transfers.
4. Abort: REQIN high then low before READY (mask closes), READY held 0 -> VALID falls, ABORT=1 for exactly 1 cycle, ACKOUT stays 0, DATAOUT retains the captured word.
5. Simultaneous: READY=1 in the same cycle req_s falls -> ACKOUT=1 for exactly 1 cycle, ABORT=0, state ends in IDLE.
6. PRESENT=0 and SYNC_STAGES=4 builds: PRESENT=0 outputs constant 0 under random stimulus. SYNC_STAGES=4 shows VALID latency of 5 edges.
